ascii_word_formatter: RTL and testbench
=======================================

# ascii_word_formatter

Parametrised successor to the team's fixed hex message formatter: converts a latched multi-word data message into an ASCII character stream for the UART TX path. Each message has a selectable radix (hex or binary), word separators and a CR/LF terminator. Input and output use valid/ready handshakes, so the block tolerates UART backpressure. Character pacing is enforced by a minimum inter-character interval.

## Interface
- WIDTH, 24, word width in bits; multiple of 4, range 4..64
- COUNT, 2, words per message; 1..16
- TX_INTERVAL, 4, minimum cycles between successive character acceptances; ≥1
- SEP_CHAR, 8'h5F, ASCII separator emitted between words
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- I_STB  in  1  message valid
- I_RDY  out  1  block can accept a message; high only in IDLE
- I_DAT  in  WIDTH*COUNT  message; word COUNT-1 in the top bits is sent first
- I_MODE  in  1  0 = hex, 1 = binary; sampled with I_DAT
- O_STB  out  1  character valid
- O_RDY  in  1  sink accepts character
- O_DAT  out  8  ASCII character
- O_BUSY  out  1  message in progress (not IDLE)

## Operation
- Message accept: I_STB & I_RDY at a rising edge. Latch I_DAT into the shift register and I_MODE into the mode register. Go to DIGIT.
- States and transitions:
  - IDLE -> DIGIT on accept.
  - DIGIT -> DIGIT while digits remain in the current word.
  - DIGIT -> SEP at the last digit when words remain.
  - DIGIT -> CR at the last digit of the last word.
  - SEP -> DIGIT.
  - CR -> LF.
  - LF -> IDLE.
  - Every transition out of DIGIT, SEP, CR or LF happens only on a character handshake (O_STB & O_RDY).
- Digits:
  - Hex mode: WIDTH/4 per word; top nibble mapped to "0"-"9"/"A"-"F" (uppercase); shift left 4 per accepted digit.
  - Binary mode: WIDTH per word; top bit mapped to "0"/"1"; shift left 1 per accepted digit.
- Counters: char_cnt reloads to digits-per-word − 1 on entry to DIGIT from IDLE or SEP. word_cnt reloads to COUNT − 1 on accept. Both decrement on handshake.
- Output handshake: once O_STB is asserted, O_DAT holds stable until O_RDY. O_RDY while O_STB is low has no effect.
- Pacing: after each handshake, O_STB stays low for TX_INTERVAL − 1 cycles. TX_INTERVAL = 1 allows back-to-back characters.
- Characters per message:
  - Hex: COUNT·WIDTH/4 + (COUNT − 1) + 2.
  - Binary: COUNT·WIDTH + (COUNT − 1) + 2.
- COUNT = 1: no separator is emitted.
- I_STB while busy: ignored, because I_RDY = 0. The data is not latched.

## Timing
- Reset values: I_RDY = 1 after reset deasserts (0 while RST_N is low); O_STB = 0; O_DAT = 8'h00; O_BUSY = 0; state = IDLE; pacer expired.
- Accept at edge k: O_STB = 1 with the first character from edge k+1.
- Handshake at edge n: next O_STB no earlier than edge n+TX_INTERVAL, or edge n+1 when TX_INTERVAL = 1.
- Last LF handshake at edge m: I_RDY = 1 and O_BUSY = 0 from edge m+1. The earliest next accept is at edge m+1.
- O_RDY held low indefinitely: block stalls; O_STB and O_DAT are held and the state is frozen.
- RST_N asserted mid-message: O_STB drops to 0 asynchronously and the message is discarded. No partial message resumes after reset.

## Configuration
- ASCII_FMT_BIN_EN defined: I_MODE selects hex or binary as above.
- ASCII_FMT_BIN_EN undefined:
  - I_MODE is ignored and hex is always used.
  - The mode register and binary digit path are not synthesised.
  - Character count is always the hex formula.

## Structure
- Package ascii_fmt_pkg holds:
  - state enum (IDLE, DIGIT, SEP, CR, LF)
  - constants ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
  - function nibble_to_ascii
- Sub-module tx_pacer (parameter TX_INTERVAL):
  - input: handshake pulse
  - output: ready flag
  - internal: down-counter of width $clog2(TX_INTERVAL+1), async active-low reset

## Test plan
- WIDTH=24, COUNT=2, TX_INTERVAL=4, hex, I_DAT=48'h0123AB_CDEF98, O_RDY=1 -> stream "0123AB_CDEF98\r\n" (15 chars); consecutive O_STB pulses spaced exactly 4 cycles apart.
- Same config, binary mode, I_DAT=48'h800001_000000 -> 51 chars: "1", 22×"0", "1", "_", 24×"0", CR, LF.
- O_RDY toggled pseudo-randomly -> identical character sequence; O_DAT never changes while O_STB=1 & O_RDY=0.
- Second I_STB pulsed with different data during transmission -> ignored; output matches the first message only; next accept occurs at edge m+1.
- RST_N low for 1 cycle after the 5th character -> O_STB=0 immediately; I_RDY=1 after release; a new message is sent complete from its first char.
- COUNT=1, WIDTH=4, TX_INTERVAL=1, I_DAT=4'hF -> "F", CR, LF on three consecutive cycles; no separator.

Source files
------------

// File: rtl/ascii_fmt_pkg.sv
// Shared types, constants and helpers for the ASCII word formatter.
// Holds the FSM state encoding and the nibble-to-character mapping.
package ascii_fmt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDigit,
    StSep,
    StCr,
    StLf
  } fmt_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: 0-9 -> 0x30.., A-F -> 0x41..
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/ascii_word_formatter_if.sv
// Message-in / character-out handshake bundle for ascii_word_formatter.
// slave is the formatter side, master is the producer/sink side.
interface ascii_word_formatter_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned COUNT = 2
) ();

  logic                     i_stb;
  logic                     i_rdy;
  logic [WIDTH*COUNT-1:0]   i_dat;
  logic                     i_mode;
  logic                     o_stb;
  logic                     o_rdy;
  logic [7:0]               o_dat;
  logic                     o_busy;

  modport slave (
    input  i_stb, i_dat, i_mode, o_rdy,
    output i_rdy, o_stb, o_dat, o_busy
  );

  modport master (
    output i_stb, i_dat, i_mode, o_rdy,
    input  i_rdy, o_stb, o_dat, o_busy
  );

endinterface

// File: rtl/tx_pacer.sv
// Minimum-interval pacer: after a handshake pulse, o_ready drops for
// TX_INTERVAL-1 cycles. TX_INTERVAL = 1 keeps o_ready permanently high.
module tx_pacer #(
  parameter int unsigned TX_INTERVAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_hs,
  output logic o_ready
);

  localparam int unsigned CntW = $clog2(TX_INTERVAL + 1);
  localparam logic [CntW-1:0] Reload = CntW'(TX_INTERVAL - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_ready;

  // Ready is registered so it is high exactly when the counter has reached zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else if (i_hs) begin
      r_cnt   <= Reload;
      r_ready <= (Reload == '0);
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - CntW'(1);
      r_ready <= (r_cnt == CntW'(1));
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/ascii_word_formatter.sv
// Converts a latched multi-word message into an ASCII stream: digits, separators, CR, LF.
// Binary radix is only built when ASCII_FMT_BIN_EN is defined; otherwise hex only.
module ascii_word_formatter
  import ascii_fmt_pkg::*;
#(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned COUNT       = 2,
  parameter int unsigned TX_INTERVAL = 4,
  parameter logic [7:0]  SEP_CHAR    = 8'h5F
) (
  input logic                   clk,
  input logic                   rst_n,
  ascii_word_formatter_if.slave bus
);

  localparam int unsigned MsgW  = WIDTH * COUNT;
  localparam int unsigned CharW = $clog2(WIDTH + 1);
  localparam int unsigned WordW = (COUNT > 1) ? $clog2(COUNT) : 1;

  localparam logic [CharW-1:0] HexLast  = CharW'(WIDTH / 4 - 1);
  localparam logic [CharW-1:0] BinLast  = CharW'(WIDTH - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(COUNT - 1);

  fmt_state_e        r_state, w_state_d;
  logic [MsgW-1:0]   r_shift, w_shift_d;
  logic [CharW-1:0]  r_char_cnt, w_char_cnt_d;
  logic [WordW-1:0]  r_word_cnt, w_word_cnt_d;
  logic              r_i_rdy;
  logic              r_busy;
  logic [7:0]        r_o_dat, w_dat_d;

  logic              w_pace_rdy;
  logic              w_o_stb;
  logic              w_hs;
  logic              w_accept;
  logic              w_mode_bin;
  logic              w_mode_d;

  assign w_o_stb  = (r_state != StIdle) & w_pace_rdy;
  assign w_hs     = w_o_stb & bus.o_rdy;
  // r_i_rdy is only high in idle, so it doubles as the accept qualifier.
  assign w_accept = bus.i_stb & r_i_rdy;

`ifdef ASCII_FMT_BIN_EN
  logic r_mode;

  assign w_mode_bin = r_mode;
  assign w_mode_d   = w_accept ? bus.i_mode : r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else begin
      r_mode <= w_mode_d;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = bus.i_mode;
  assign w_mode_bin    = 1'b0;
  assign w_mode_d      = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_char_cnt_d = r_char_cnt;
    w_word_cnt_d = r_word_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d    = StDigit;
          w_shift_d    = bus.i_dat;
          w_char_cnt_d = w_mode_d ? BinLast : HexLast;
          w_word_cnt_d = WordLast;
        end
      end
      StDigit: begin
        if (w_hs) begin
          w_shift_d = w_mode_bin ? (r_shift << 1) : (r_shift << 4);
          if (r_char_cnt != '0) begin
            w_char_cnt_d = r_char_cnt - CharW'(1);
          end else if (r_word_cnt != '0) begin
            w_state_d    = StSep;
            w_word_cnt_d = r_word_cnt - WordW'(1);
          end else begin
            w_state_d = StCr;
          end
        end
      end
      StSep: begin
        if (w_hs) begin
          w_state_d    = StDigit;
          w_char_cnt_d = w_mode_bin ? BinLast : HexLast;
        end
      end
      StCr: begin
        if (w_hs) w_state_d = StLf;
      end
      StLf: begin
        if (w_hs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Character presented in the next state; the next word is already at the top of the shifter.
  always_comb begin
    w_dat_d = 8'h00;
    unique case (w_state_d)
      StDigit: begin
        w_dat_d = w_mode_d ? {7'h18, w_shift_d[MsgW-1]}
                           : nibble_to_ascii(w_shift_d[MsgW-1 -: 4]);
      end
      StSep:   w_dat_d = SEP_CHAR;
      StCr:    w_dat_d = ASCII_CR;
      StLf:    w_dat_d = ASCII_LF;
      default: w_dat_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_char_cnt <= '0;
      r_word_cnt <= '0;
      r_i_rdy    <= 1'b0;
      r_busy     <= 1'b0;
      r_o_dat    <= 8'h00;
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_char_cnt <= w_char_cnt_d;
      r_word_cnt <= w_word_cnt_d;
      r_i_rdy    <= (w_state_d == StIdle);
      r_busy     <= (w_state_d != StIdle);
      r_o_dat    <= w_dat_d;
    end
  end

  tx_pacer #(
    .TX_INTERVAL(TX_INTERVAL)
  ) u_pacer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_hs   (w_hs),
    .o_ready(w_pace_rdy)
  );

  assign bus.i_rdy  = r_i_rdy;
  assign bus.o_stb  = w_o_stb;
  assign bus.o_dat  = r_o_dat;
  assign bus.o_busy = r_busy;

endmodule

// File: tb/tb_ascii_word_formatter.sv
// Bench for ascii_word_formatter: directed messages against a string-building model,
// plus a small COUNT=1/WIDTH=4/TX_INTERVAL=1 instance checked with literals.
module tb_ascii_word_formatter;

  localparam int unsigned W   = 24;
  localparam int unsigned C   = 2;
  localparam int unsigned TXI = 4;

`ifdef ASCII_FMT_BIN_EN
  localparam bit BinEn = 1'b1;
`else
  localparam bit BinEn = 1'b0;
`endif
  localparam int BinLen = BinEn ? 51 : 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascii_word_formatter_if #(.WIDTH(W), .COUNT(C)) bus ();
  ascii_word_formatter_if #(.WIDTH(4), .COUNT(1)) bus1 ();

  ascii_word_formatter #(
    .WIDTH(W), .COUNT(C), .TX_INTERVAL(TXI), .SEP_CHAR(8'h5F)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  ascii_word_formatter #(
    .WIDTH(4), .COUNT(1), .TX_INTERVAL(1), .SEP_CHAR(8'h5F)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int hs_total = 0;
  int hs_base = 0;
  int last_hs_edge = -1;
  int lf_edge = -1;
  bit pace_exact = 1'b0;
  bit rdy_rand = 1'b0;
  bit rdy_low = 1'b0;
  bit stall_v = 1'b0;
  logic [7:0] held;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected text straight from the message rules: per word, top word first.
  function automatic void build_model(input logic [W*C-1:0] data, input logic mode);
    logic       eff;
    logic [W-1:0] word;
    int         v;
    eff = mode & BinEn;
    mdl_q.delete();
    for (int w = C - 1; w >= 0; w--) begin
      word = data[w*W +: W];
      if (eff) begin
        for (int b = W - 1; b >= 0; b--) mdl_q.push_back(word[b] ? 8'h31 : 8'h30);
      end else begin
        for (int d = W / 4 - 1; d >= 0; d--) begin
          v = int'(word[d*4 +: 4]);
          mdl_q.push_back(v < 10 ? 8'(48 + v) : 8'(55 + v));
        end
      end
      if (w != 0) mdl_q.push_back(8'h5F);
    end
    mdl_q.push_back(8'h0D);
    mdl_q.push_back(8'h0A);
  endfunction

  task automatic send(input logic [W*C-1:0] data, input logic mode, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.i_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: i_rdy is %b, expected 1", bus.i_rdy);
      return;
    end
    bus.i_dat  = data;
    bus.i_mode = mode;
    bus.i_stb  = 1'b1;
    @(posedge clk);
    #1;
    acc       = cyc;
    bus.i_stb = 1'b0;
    build_model(data, mode);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    hs_base = hs_total;
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (hs_total - hs_base >= n) return;
    end
    n_vec++;
    n_miss++;
    $display("FAIL hs_timeout: got %0d chars, expected %0d", hs_total - hs_base, n);
  endtask

  task automatic wait_done(input int len);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && bus.o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: %0d chars pending, expected 0", exp_q.size());
    end
    check("msg_len", hs_total - hs_base, len);
    check("idle_i_rdy", bus.i_rdy, 1'b1);
  endtask

  initial begin
    bus.o_rdy  = 1'b1;
    bus1.o_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.o_rdy = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Compare process: every character handshake against the model queue, plus hold and pacing.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_v      = 1'b0;
      last_hs_edge = -1;
    end else begin
      if (stall_v) begin
        check("stall_stb", bus.o_stb, 1'b1);
        check("stall_dat", bus.o_dat, held);
      end
      if (bus.o_stb === 1'b1 && bus.o_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_char: got %0h, expected none", bus.o_dat);
        end else begin
          if (exp_q[0] == 8'h0A) lf_edge = cyc + 1;
          check("char", bus.o_dat, exp_q.pop_front());
        end
        if (last_hs_edge >= 0) begin
          if (pace_exact) check("pace_exact", cyc + 1 - last_hs_edge, TXI);
          else check("pace_min", (cyc + 1 - last_hs_edge) >= int'(TXI), 1'b1);
        end
        last_hs_edge = cyc + 1;
        hs_total++;
        stall_v = 1'b0;
      end else if (bus.o_stb === 1'b1) begin
        stall_v = 1'b1;
        held    = bus.o_dat;
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc;
    int    acc2;
    int    k;
    string s;
    bus.i_stb   = 1'b0;
    bus.i_dat   = '0;
    bus.i_mode  = 1'b0;
    bus1.i_stb  = 1'b0;
    bus1.i_dat  = '0;
    bus1.i_mode = 1'b0;

    // Reset values
    #23;
    check("rst_i_rdy", bus.i_rdy, 1'b0);
    check("rst_o_stb", bus.o_stb, 1'b0);
    check("rst_o_dat", bus.o_dat, 8'h00);
    check("rst_o_busy", bus.o_busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_i_rdy", bus.i_rdy, 1'b1);
    check("post_rst_o_stb", bus.o_stb, 1'b0);

    // Hex message, sink always ready, exact pacing
    pace_exact = 1'b1;
    send(48'h0123AB_CDEF98, 1'b0, acc);
    s = "0123AB_CDEF98";
    check("model_hex_len", mdl_q.size(), 15);
    for (int i = 0; i < 13; i++) check("model_hex_char", mdl_q[i], s.getc(i));
    check("model_hex_cr", mdl_q[13], 8'h0D);
    check("model_hex_lf", mdl_q[14], 8'h0A);
    wait_hs(1);
    check("first_char_latency", last_hs_edge - acc, 1);
    wait_done(15);
    pace_exact = 1'b0;

    // Binary request (hex when the binary path is not built)
    send(48'h800001_000000, 1'b1, acc);
`ifdef ASCII_FMT_BIN_EN
    check("model_bin_len", mdl_q.size(), 51);
    check("model_bin_0", mdl_q[0], 8'h31);
    check("model_bin_1", mdl_q[1], 8'h30);
    check("model_bin_23", mdl_q[23], 8'h31);
    check("model_bin_sep", mdl_q[24], 8'h5F);
    check("model_bin_cr", mdl_q[49], 8'h0D);
`else
    check("model_hexonly_len", mdl_q.size(), 15);
    check("model_hexonly_0", mdl_q[0], 8'h38);
    check("model_hexonly_sep", mdl_q[6], 8'h5F);
`endif
    wait_done(BinLen);

    // Random backpressure
    rdy_rand = 1'b1;
    send(48'h0123AB_CDEF98, 1'b0, acc);
    wait_done(15);
    rdy_rand = 1'b0;

    // Stray message strobe while busy, then earliest next accept
    send(48'hFEDCBA_987654, 1'b0, acc);
    repeat (6) @(posedge clk);
    #1;
    check("busy_i_rdy", bus.i_rdy, 1'b0);
    bus.i_dat = 48'h111111_222222;
    bus.i_stb = 1'b1;
    @(posedge clk);
    #1 bus.i_stb = 1'b0;
    send(48'h0A0B0C_0D0E0F, 1'b0, acc2);
    check("next_accept_edge", acc2 - lf_edge, 1);
    wait_done(15);

    // Reset after the 5th character
    send(48'h13579B_DF2468, 1'b0, acc);
    wait_hs(5);
    rst_n = 1'b0;
    #1;
    check("midrst_o_stb", bus.o_stb, 1'b0);
    check("midrst_o_busy", bus.o_busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_i_rdy", bus.i_rdy, 1'b1);
    send(48'h2468AC_E13579, 1'b0, acc);
    wait_done(15);

    // Indefinite stall
    send(48'hABCDEF_012345, 1'b0, acc);
    wait_hs(3);
    rdy_low = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("stall_long_stb", bus.o_stb, 1'b1);
    check("stall_long_busy", bus.o_busy, 1'b1);
    check("stall_long_no_hs", hs_total - hs_base, 3);
    rdy_low = 1'b0;
    wait_done(15);

    // COUNT=1, WIDTH=4, TX_INTERVAL=1: F, CR, LF back to back
    @(negedge clk);
    bus1.i_dat = 4'hF;
    bus1.i_stb = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    bus1.i_stb = 1'b0;
    check("small_c0_stb", bus1.o_stb, 1'b1);
    check("small_c0_dat", bus1.o_dat, 8'h46);
    @(posedge clk);
    #1;
    check("small_c1_stb", bus1.o_stb, 1'b1);
    check("small_c1_dat", bus1.o_dat, 8'h0D);
    @(posedge clk);
    #1;
    check("small_c2_stb", bus1.o_stb, 1'b1);
    check("small_c2_dat", bus1.o_dat, 8'h0A);
    @(posedge clk);
    #1;
    check("small_done_edge", cyc - k, 3);
    check("small_done_stb", bus1.o_stb, 1'b0);
    check("small_done_busy", bus1.o_busy, 1'b0);
    check("small_done_i_rdy", bus1.i_rdy, 1'b1);

    repeat (5) @(posedge clk);
    #2;
    check("no_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
